// File: rtl/maskmul_seq_pkg.sv
// Shared definitions for the masked-multiplier sequencer: FSM states,
// share width and the default mask-LFSR seed/taps.
package maskmul_seq_pkg;

    localparam int SHARE_W = 2;
    localparam int LFSR_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        HOLD
    } state_e;

endpackage

// File: rtl/mask_lfsr.sv
// Galois LFSR supplying fresh output masks; a zero reload value falls back
// to SEED so the register can never lock up in the all-zero state.
module mask_lfsr
    import maskmul_seq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF,
    parameter logic [LFSR_W-1:0] TAPS = LFSR_TAPS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // A load takes priority over a step issued in the same cycle.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/maskmul.sv
// Masked GF(2^2) multiplier (field polynomial x^2+x+1) with one cycle of
// registered latency: qm = (am^ma)*(bm^mb) ^ mq, computed share-wise.
module maskmul (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] am,
    input  logic [1:0] bm,
    input  logic [1:0] ma,
    input  logic [1:0] mb,
    input  logic [1:0] mq,
    output logic [1:0] qm
);

    function automatic logic [1:0] gf4Mul(input logic [1:0] a, input logic [1:0] b);
        logic c2;
        logic c1;
        logic c0;
        c2 = a[1] & b[1];
        c1 = (a[1] & b[0]) ^ (a[0] & b[1]);
        c0 = a[0] & b[0];
        return {c1 ^ c2, c0 ^ c2};
    endfunction

    logic [1:0] qm_q;
    logic [1:0] qm_d;

    // The fresh mask is folded in first so no partial sum ever equals the
    // unmasked product.
    always_comb begin
        qm_d = mq;
        qm_d = qm_d ^ gf4Mul(am, bm);
        qm_d = qm_d ^ gf4Mul(am, mb);
        qm_d = qm_d ^ gf4Mul(ma, bm);
        qm_d = qm_d ^ gf4Mul(ma, mb);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qm_q <= '0;
        end else begin
            qm_q <= qm_d;
        end
    end

    assign qm = qm_q;

endmodule

// File: rtl/maskmul_seq.sv
// Sequencer around one masked multiplier: accepts an operand in IDLE, draws a
// fresh output mask from the LFSR, and holds the result until it is taken.
module maskmul_seq
    import maskmul_seq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHARE_W-1:0] in_am,
    input  logic [SHARE_W-1:0] in_bm,
    input  logic [SHARE_W-1:0] in_ma,
    input  logic [SHARE_W-1:0] in_mb,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHARE_W-1:0] out_qm,
    output logic [SHARE_W-1:0] out_mq,
    output logic               busy,
    output logic [7:0]         done_cnt
);

    state_e state_q;
    state_e state_d;

    logic [SHARE_W-1:0] am_q, bm_q, ma_q, mb_q, mq_q;
    logic [SHARE_W-1:0] out_qm_q, out_mq_q;
    logic [7:0]         done_cnt_q;

    logic accept;
    logic reseed;
    logic capture;
    logic retire;

    logic [LFSR_W-1:0]         lfsr_state;
    logic [LFSR_W-SHARE_W-1:0] lfsr_unused;

    logic [SHARE_W-1:0] mm_am, mm_bm, mm_ma, mm_mb, mm_mq, mm_qm;

    // A reseed request masks in_ready so an operand offered in the same
    // cycle is taken on the next one, with a mask from the new seed.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        reseed   = 1'b0;
        capture  = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                reseed   = seed_load;
                in_ready = ~seed_load;
                accept   = in_valid & ~seed_load;
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPT;
            end
            CAPT: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                retire = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            am_q <= '0;
            bm_q <= '0;
            ma_q <= '0;
            mb_q <= '0;
            mq_q <= '0;
        end else if (accept) begin
            am_q <= in_am;
            bm_q <= in_bm;
            ma_q <= in_ma;
            mb_q <= in_mb;
            mq_q <= lfsr_state[SHARE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_qm_q   <= '0;
            out_mq_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            if (capture) begin
                out_qm_q <= mm_qm;
                out_mq_q <= mq_q;
            end
            if (retire) begin
                done_cnt_q <= done_cnt_q + 8'd1;
            end
        end
    end

    mask_lfsr #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (reseed),
        .load_val (seed),
        .step     (accept),
        .state    (lfsr_state)
    );

    // Only the low bits feed the mask; the rest is LFSR history.
    assign lfsr_unused = lfsr_state[LFSR_W-1:SHARE_W];

    // Operands reach the multiplier only during ISSUE and are zero otherwise.
    assign mm_am = (state_q == ISSUE) ? am_q : '0;
    assign mm_bm = (state_q == ISSUE) ? bm_q : '0;
    assign mm_ma = (state_q == ISSUE) ? ma_q : '0;
    assign mm_mb = (state_q == ISSUE) ? mb_q : '0;
    assign mm_mq = (state_q == ISSUE) ? mq_q : '0;

    maskmul u_maskmul (
        .clk   (clk),
        .reset (reset),
        .am    (mm_am),
        .bm    (mm_bm),
        .ma    (mm_ma),
        .mb    (mm_mb),
        .mq    (mm_mq),
        .qm    (mm_qm)
    );

    assign out_valid = (state_q == HOLD);
    assign out_qm    = out_qm_q;
    assign out_mq    = out_mq_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;

endmodule

// File: doc/maskmul_seq.md
MASKMUL_SEQ -- requirements
Module: maskmul_seq

Interface
REQ-001 The block SHALL have parameter LFSR_SEED, default 16'hACE1, the mask-LFSR state after reset.
REQ-002 The block SHALL have parameter LFSR_TAPS, default 16'hB400, the Galois toggle mask (x^16+x^14+x^13+x^11+1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operand handshake.
REQ-006 The block SHALL have ports in_am, in_bm, in_ma, in_mb (input, 2 each), the masked operands and their input masks.
REQ-007 The block SHALL have ports seed_load (input, 1) and seed (input, 16), the LFSR reseed request.
REQ-008 The block SHALL have ports out_valid (input, 1 -- output) and out_ready (input, 1), the result handshake.
REQ-009 The block SHALL have ports out_qm and out_mq (output, 2 each), the masked product and its output mask.
REQ-010 The block SHALL have ports busy (output, 1, FSM not IDLE) and done_cnt (output, 8, completed results).

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, CAPT and HOLD.
REQ-012 IDLE: in_ready=1; an in_valid&in_ready cycle SHALL latch all four operands, the mq drawn from lfsr[1:0], and step the LFSR; next state ISSUE.
REQ-013 ISSUE: latched am, bm, ma, mb, mq SHALL drive the maskmul instance for exactly one cycle; next state CAPT.
REQ-014 CAPT: maskmul qm (1-cycle registered latency) SHALL be captured into out_qm with the latched mq into out_mq; out_valid rises next cycle; next state HOLD.
REQ-015 HOLD: out_valid=1 with out_qm/out_mq stable until out_valid&out_ready; on that cycle done_cnt increments and the FSM returns to IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; the minimum issue-to-issue spacing SHALL be 4 cycles with out_ready held high.
REQ-017 An LFSR step SHALL be: if lsb=1, state=(state>>1)^LFSR_TAPS, else state=state>>1.
REQ-018 seed_load SHALL be honoured only in IDLE; it loads seed, or LFSR_SEED if seed==0; it is ignored in other states.
REQ-019 seed_load and an accepted in_valid in the same IDLE cycle: the reseed SHALL win; the operand SHALL be accepted next cycle with mq from the new seed.
REQ-020 done_cnt SHALL wrap from 255 to 0 without flagging.
REQ-021 Operand inputs SHALL be ignored when in_ready=0; out_ready SHALL be ignored when out_valid=0.
REQ-022 The block SHALL never present a result whose mq equals a value reused from a prior operation without an intervening LFSR step.

Reset
REQ-023 reset low SHALL asynchronously force: FSM=IDLE, LFSR=LFSR_SEED, out_valid=0, out_qm=0, out_mq=0, done_cnt=0, busy=0, all operand latches=0.
REQ-024 reset mid-operation (ISSUE/CAPT/HOLD) SHALL discard the in-flight result with no out_valid pulse after release.
REQ-025 The first in_ready after reset release SHALL occur in the first cycle after deassertion.

Structure
REQ-026 The shared package SHALL hold the FSM state enum, LFSR_SEED and LFSR_TAPS defaults, and the 2-bit share width.
REQ-027 The block SHALL instantiate exactly one existing maskmul sub-module, unchanged, sharing clk and reset.
REQ-028 The LFSR SHALL be a sub-module mask_lfsr (load, step, state).

Verification
REQ-029 Scenario: reset, then one operand am=2'b10, bm=2'b11, ma=2'b01, mb=2'b10 -> out_mq=2'b01, out_qm^out_mq equals the maskmul golden model product of 2'b11 and 2'b01.
REQ-030 Scenario: second operand after reset -> out_mq=2'b00 (LFSR state 16'hE270).
REQ-031 Scenario: out_ready low for 10 cycles in HOLD -> out_valid, out_qm, out_mq stable, in_ready=0 throughout.
REQ-032 Scenario: seed_load with seed=0 in IDLE -> LFSR=16'hACE1; seed=16'h0002 with in_valid same cycle -> operand accepted one cycle later, mq=2'b10.
REQ-033 Scenario: reset asserted in CAPT -> out_valid stays 0, done_cnt=0, next accepted op gets mq=2'b01.
REQ-034 Scenario: 256 back-to-back ops with out_ready=1 -> done_cnt=0, spacing exactly 4 cycles, every result matches golden model.
